clk_div_select_x: RTL

CLK_DIV_SELECT_X -- requirements
Module: clk_div_select_x

---
 rtl/clk_div_select_x.sv | 134 +++++++++++++
 1 files changed

// File: rtl/clk_div_select_x.sv
// rtl/clk_div_select_x.sv - glitch-free selectable clock divider
// Switches between divide slots only at the end of a low phase so no runt pulse is produced.
module clk_div_select_x #(
  parameter int unsigned NUM_SEL = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic                     sel_vld_i,
  input  logic [NUM_SEL*CNT_W-1:0] div_tab_i,
  output logic                     clk_div_o,
  output logic                     clk_en_o,
  output logic [SEL_W-1:0]         sel_cur_o,
  output logic                     busy_o,
  output logic                     sel_ack_o,
  output logic                     err_o
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_PEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] d_cur_q, d_cur_d;
  logic [CNT_W-1:0] d_req, d_pend;
  logic [SEL_W-1:0] sel_pend_q, sel_pend_d, sel_cur_d;
  logic             div_d, en_d, ack_d, err_d;
  logic             in_range, req_ok, req_bad, phase_end;

  // Table lookups by comparison so an out-of-range index never forms an illegal slice.
  always_comb begin
    d_req  = '0;
    d_pend = '0;
    for (int unsigned k = 0; k < NUM_SEL; k++) begin
      if (sel_i == SEL_W'(k))      d_req  = div_tab_i[k*CNT_W +: CNT_W];
      if (sel_pend_q == SEL_W'(k)) d_pend = div_tab_i[k*CNT_W +: CNT_W];
    end
  end

  assign busy_o    = (state_q == ST_PEND);
  assign in_range  = (32'(sel_i) < NUM_SEL);
  assign req_ok    = sel_vld_i && !busy_o && in_range;
  assign req_bad   = sel_vld_i && !busy_o && !in_range;
  assign phase_end = (cnt_q == d_cur_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    d_cur_d    = d_cur_q;
    sel_cur_d  = sel_cur_o;
    sel_pend_d = sel_pend_q;
    div_d      = clk_div_o;
    en_d       = 1'b0;
    ack_d      = 1'b0;
    err_d      = req_bad;

    if (state_q != ST_STOP) begin
      if (phase_end) begin
        cnt_d = '0;
        div_d = !clk_div_o;
        en_d  = !clk_div_o;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_STOP: begin
        if (req_ok) begin
          sel_cur_d = sel_i;
          d_cur_d   = d_req;
          cnt_d     = '0;
          ack_d     = 1'b1;
          if (d_req != '0) begin
            state_d = ST_RUN;
            div_d   = 1'b1;
            en_d    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (req_ok) begin
          state_d    = ST_PEND;
          sel_pend_d = sel_i;
        end
      end
      ST_PEND: begin
        // Switch only where the low phase ends, so the next edge is a clean rise.
        if (phase_end && !clk_div_o) begin
          sel_cur_d = sel_pend_q;
          d_cur_d   = d_pend;
          cnt_d     = '0;
          ack_d     = 1'b1;
          if (d_pend != '0) begin
            state_d = ST_RUN;
            div_d   = 1'b1;
            en_d    = 1'b1;
          end else begin
            state_d = ST_STOP;
            div_d   = 1'b0;
            en_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      d_cur_q    <= '0;
      sel_cur_o  <= '0;
      sel_pend_q <= '0;
      clk_div_o  <= 1'b0;
      clk_en_o   <= 1'b0;
      sel_ack_o  <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      d_cur_q    <= d_cur_d;
      sel_cur_o  <= sel_cur_d;
      sel_pend_q <= sel_pend_d;
      clk_div_o  <= div_d;
      clk_en_o   <= en_d;
      sel_ack_o  <= ack_d;
      err_o      <= err_d;
    end
  end

endmodule
